// File: rtl/serial_mag_cmp.sv
// Bit-serial unsigned magnitude comparator.
// Walks both operands MSB-first and stops at the first differing bit.
module serial_mag_cmp #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done,
    output logic         eq,
    output logic         gt,
    output logic         lt
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [N-1:0]  sa, sb;
    logic [CW-1:0] cnt;
    logic          eq_r, gt_r, lt_r;
    logic          x, y, e, last;

    assign x    = sa[N-1];
    assign y    = sb[N-1];
    assign e    = (x & y) | (~x & ~y);
    assign last = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                if (!e || last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Flags are cleared on acceptance and set only on the edge into DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            sa   <= '0;
            sb   <= '0;
            cnt  <= '0;
            eq_r <= 1'b0;
            gt_r <= 1'b0;
            lt_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa   <= a;
                        sb   <= b;
                        cnt  <= CW'(N);
                        eq_r <= 1'b0;
                        gt_r <= 1'b0;
                        lt_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (!e) begin
                        gt_r <= x & ~y;
                        lt_r <= ~x & y;
                    end else if (last) begin
                        eq_r <= 1'b1;
                    end else begin
                        sa  <= sa << 1;
                        sb  <= sb << 1;
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign eq = eq_r;
    assign gt = gt_r;
    assign lt = lt_r;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Directed and random checks for serial_mag_cmp at N=8 and N=1.
// Cycle c is the period after accepting edge c; sampling is on negedges.
module tb_serial_mag_cmp;

    logic       clk = 1'b0;
    logic       reset;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic       ready8, done8, eq8, gt8, lt8;
    logic       ready1, done1, eq1, gt1, lt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_mag_cmp #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .done(done8), .eq(eq8), .gt(gt8), .lt(lt8)
    );

    serial_mag_cmp #(.N(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1),
        .ready(ready1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model_flags(input int x, input int y);
        if (x == y) return 3'b100;
        if (x > y)  return 3'b010;
        return 3'b001;
    endfunction

    function automatic int model_lat8(input logic [7:0] x, input logic [7:0] y);
        for (int k = 0; k < 8; k++)
            if (x[7-k] != y[7-k]) return k + 2;
        return 9;
    endfunction

    // Returns at the negedge of cycle 1.
    task automatic go(input bit sel, input logic [7:0] va, input logic [7:0] vb);
        @(negedge clk);
        if (sel) begin
            check("ready1_pre", ready1, 1);
            a1 = va[0]; b1 = vb[0]; start1 = 1'b1;
        end else begin
            check("ready8_pre", ready8, 1);
            a8 = va; b8 = vb; start8 = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output int cyc);
        cyc = 1;
        while (!(sel ? done1 : done8) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!(sel ? done1 : done8)) cyc = -1;
    endtask

    initial begin
        int lat, n;
        logic [7:0] ra, rb;

        reset = 1'b1;
        start8 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        check("reset8", {ready8, done8, eq8, gt8, lt8}, 5'b10000);
        check("reset1", {ready1, done1, eq1, gt1, lt1}, 5'b10000);
        reset = 1'b0;

        go(0, 8'hA5, 8'hA5);
        check("a5_run_ready", ready8, 0);
        wait_done(0, lat);
        check("a5_lat", lat, 9);
        check("a5_flags", {eq8, gt8, lt8}, 3'b100);
        @(negedge clk);
        check("a5_ready_back", {ready8, done8}, 2'b10);

        go(0, 8'h80, 8'h7F);
        wait_done(0, lat);
        check("80_lat", lat, 2);
        check("80_flags", {eq8, gt8, lt8}, 3'b010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("80_hold", {done8, eq8, gt8, lt8}, 4'b0010);
        end

        go(0, 8'h12, 8'h13);
        wait_done(0, lat);
        check("12_lat", lat, 9);
        check("12_flags", {eq8, gt8, lt8}, 3'b001);
        go(0, 8'hFF, 8'h00);
        check("ff_cleared", {ready8, eq8, gt8, lt8}, 4'b0000);
        wait_done(0, lat);
        check("ff_lat", lat, 2);
        check("ff_flags", {eq8, gt8, lt8}, 3'b010);

        // Start held high with noisy operands throughout RUN and DONE.
        go(0, 8'h3C, 8'h3D);
        start8 = 1'b1;
        n = 0; lat = -1;
        for (int c = 1; c <= 25; c++) begin
            if (done8) begin
                n++;
                if (lat < 0) lat = c;
                check("spam_flags", {eq8, gt8, lt8}, 3'b001);
                start8 = 1'b0;
            end else if (n == 0) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        check("spam_dones", n, 1);
        check("spam_lat", lat, 9);
        check("spam_idle", ready8, 1);

        go(0, 8'h0F, 8'h0E);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst", {ready8, done8, eq8, gt8, lt8}, 5'b10000);
        n = 0;
        for (int c = 0; c < 15; c++) begin
            if (done8) n++;
            @(negedge clk);
        end
        check("midrst_nodone", n, 0);
        go(0, 8'h0F, 8'h0E);
        wait_done(0, lat);
        check("fresh_lat", lat, 9);
        check("fresh_flags", {eq8, gt8, lt8}, 3'b010);

        for (int i = 0; i < 4; i++) begin
            ra = 8'(i >> 1);
            rb = 8'(i & 1);
            go(1, ra, rb);
            wait_done(1, lat);
            check("n1_lat", lat, 2);
            check("n1_flags", {eq1, gt1, lt1}, model_flags(ra, rb));
        end

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            case (i % 4)
                0:       rb = ra;
                1:       rb = ra ^ (8'h01 << $urandom_range(7, 0));
                default: rb = 8'($urandom);
            endcase
            go(0, ra, rb);
            wait_done(0, lat);
            check("rnd_lat", lat, model_lat8(ra, rb));
            check("rnd_flags", {eq8, gt8, lt8}, model_flags(ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
